video_route: RTL and testbench

VIDEO_ROUTE -- requirements
Module: video_route

---
 rtl/video_route_pkg.sv | 23 ++
 rtl/video_route_if.sv | 15 +
 rtl/route_out_reg.sv | 63 ++++++
 rtl/video_route.sv | 106 ++++++++++
 tb/tb_video_route.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_route_pkg.sv
// Shared constants for the video router: FSM encoding, route-word field
// positions and counter width.
package video_route_pkg;

    localparam int unsigned SEL_LSB = 0;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned EN_BIT  = 31;
    localparam int unsigned CNT_W   = 16;

    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_PASS     = 2'd1;
    localparam logic [1:0] ST_DROP     = 2'd2;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // A route forwards only when enabled and pointing at an existing pipe.
    function automatic logic route_ok(input logic en, input sel_t sel,
                                      input int unsigned num_pipes);
        return en && (32'(sel) < num_pipes);
    endfunction

endpackage

// File: rtl/video_route_if.sv
// AXI-Stream bundle with LANES parallel lanes sharing one data width;
// tdata lane k occupies slice k.
interface video_route_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 1
);
    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tready;
    logic [LANES-1:0]        tlast;
    logic [LANES-1:0]        tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/route_out_reg.sv
// Single output register with destination tag; presents its beat on the
// tagged pipe only and holds it until that pipe accepts.
module route_out_reg
    import video_route_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned NUM_PIPES   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [TDATA_WIDTH-1:0] in_data,
    input  logic                   in_last,
    input  logic                   in_user,
    input  sel_t                   in_dest,
    output logic                   out_valid,
    output logic                   can_load,
    video_route_if.master          m_axis
);

    logic [TDATA_WIDTH-1:0] data_q;
    logic                   last_q;
    logic                   user_q;
    sel_t                   dest_q;
    logic                   dest_ready;
    logic [NUM_PIPES-1:0]   valid_vec;

    always_comb begin
        dest_ready = 1'b0;
        valid_vec  = '0;
        for (int unsigned k = 0; k < NUM_PIPES; k++) begin
            if (dest_q == sel_t'(k)) begin
                dest_ready   = m_axis.tready[k];
                valid_vec[k] = out_valid;
            end
        end
    end

    assign can_load      = !out_valid || dest_ready;
    assign m_axis.tvalid = valid_vec;
    assign m_axis.tdata  = {NUM_PIPES{data_q}};
    assign m_axis.tlast  = {NUM_PIPES{last_q}};
    assign m_axis.tuser  = {NUM_PIPES{user_q}};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            user_q    <= 1'b0;
            dest_q    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            data_q    <= in_data;
            last_q    <= in_last;
            user_q    <= in_user;
            dest_q    <= in_dest;
        end else if (dest_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/video_route.sv
// Frame-synchronous video router: a route word captured on vsync is committed
// at the next start of frame and steers the stream to one of NUM_PIPES pipes.
module video_route
    import video_route_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned NUM_PIPES   = 4,
    parameter int unsigned DEFAULT_SEL = 0
) (
    input  logic                   s_axis_video_aclk,
    input  logic                   s_axis_video_areset,
    input  logic                   vsync,
    input  logic [TDATA_WIDTH-1:0] APP0_tdata,
    video_route_if.slave           s_axis_video,
    video_route_if.master          m_axis,
    output sel_t                   active_sel,
    output logic                   active_en,
    output cnt_t                   frame_cnt,
    output cnt_t                   drop_cnt
);

    logic [1:0] state_q, state_d;
    sel_t       pending_sel;
    logic       pending_en, pending_flag;
    sel_t       eff_sel;
    logic       eff_en, go_pass, load_ok, out_valid;
    logic       in_ready, accept, sof_acc, load;
    logic       unused_app0;

    assign unused_app0 = ^APP0_tdata;

    // An SOF beat already rides on the route it commits; other beats see active.
    assign eff_sel = (s_axis_video.tuser[0] && pending_flag) ? pending_sel : active_sel;
    assign eff_en  = (s_axis_video.tuser[0] && pending_flag) ? pending_en  : active_en;
    assign go_pass = route_ok(eff_en, eff_sel, NUM_PIPES);

    // Outside PASS only an SOF that will be forwarded must wait for the register.
    always_comb begin
        in_ready = 1'b0;
        if (!s_axis_video_areset) begin
            if (state_q == ST_PASS)
                in_ready = load_ok;
            else
                in_ready = !(s_axis_video.tvalid[0] && s_axis_video.tuser[0] && go_pass) || load_ok;
        end
    end

    assign s_axis_video.tready = in_ready;
    assign accept  = s_axis_video.tvalid[0] && in_ready;
    assign sof_acc = accept && s_axis_video.tuser[0];
    assign load    = accept && (s_axis_video.tuser[0] ? go_pass : (state_q == ST_PASS));

    always_comb begin
        state_d = state_q;
        if (sof_acc)
            state_d = go_pass ? ST_PASS : ST_DROP;
    end

    always_ff @(posedge s_axis_video_aclk) begin
        if (s_axis_video_areset) begin
            state_q      <= ST_WAIT_SOF;
            active_sel   <= sel_t'(DEFAULT_SEL);
            active_en    <= 1'b1;
            pending_sel  <= '0;
            pending_en   <= 1'b0;
            pending_flag <= 1'b0;
            frame_cnt    <= '0;
            drop_cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (sof_acc && pending_flag) begin
                active_sel <= pending_sel;
                active_en  <= pending_en;
            end
            // A vsync coincident with SOF re-arms pending for the following frame.
            if (vsync) begin
                pending_sel  <= APP0_tdata[SEL_LSB +: SEL_W];
                pending_en   <= APP0_tdata[EN_BIT];
                pending_flag <= 1'b1;
            end else if (sof_acc) begin
                pending_flag <= 1'b0;
            end
            if (sof_acc && load)
                frame_cnt <= frame_cnt + cnt_t'(1);
            if (accept && !load)
                drop_cnt <= drop_cnt + cnt_t'(1);
        end
    end

    route_out_reg #(
        .TDATA_WIDTH (TDATA_WIDTH),
        .NUM_PIPES   (NUM_PIPES)
    ) u_out (
        .clk       (s_axis_video_aclk),
        .rst       (s_axis_video_areset),
        .load      (load),
        .in_data   (s_axis_video.tdata),
        .in_last   (s_axis_video.tlast[0]),
        .in_user   (s_axis_video.tuser[0]),
        .in_dest   (eff_sel),
        .out_valid (out_valid),
        .can_load  (load_ok),
        .m_axis    (m_axis)
    );

endmodule

// File: tb/tb_video_route.sv
// Randomized bench for video_route: a transaction-level route model feeds
// per-pipe expected-beat queues that are matched against DUT outputs.
module tb_video_route;

    localparam int TDW  = 32;
    localparam int NP   = 4;
    localparam int DSEL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic [31:0] app0 = '0;
    logic [1:0]  active_sel;
    logic        active_en;
    logic [15:0] frame_cnt, drop_cnt;

    video_route_if #(.DATA_W(TDW), .LANES(1))  s_if ();
    video_route_if #(.DATA_W(TDW), .LANES(NP)) m_if ();

    video_route #(
        .TDATA_WIDTH (TDW),
        .NUM_PIPES   (NP),
        .DEFAULT_SEL (DSEL)
    ) dut (
        .s_axis_video_aclk   (clk),
        .s_axis_video_areset (rst),
        .vsync               (vsync),
        .APP0_tdata          (app0),
        .s_axis_video        (s_if),
        .m_axis              (m_if),
        .active_sel          (active_sel),
        .active_en           (active_en),
        .frame_cnt           (frame_cnt),
        .drop_cnt            (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: route rules applied per accepted beat.
    int          m_mode  = 0;  // 0 waiting for SOF, 1 forwarding, 2 discarding
    int          m_asel  = DSEL;
    logic        m_aen   = 1'b1;
    int          m_psel  = 0;
    logic        m_pen   = 1'b0;
    logic        m_pflag = 1'b0;
    int          m_frames = 0;
    int          m_drops  = 0;
    logic [65:0] q [NP][$];
    int          npipe [NP] = '{default: 0};
    logic [NP-1:0] prev_stall = '0;
    logic [31:0] prev_data [NP];
    logic        chk_lat = 1'b0;

    logic [NP-1:0] rdy_fixed = '1;
    logic [NP-1:0] rdy_rand  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            m_mode = 0; m_asel = DSEL; m_aen = 1'b1; m_pflag = 1'b0;
            m_frames = 0; m_drops = 0;
            for (int k = 0; k < NP; k++) q[k].delete();
            prev_stall = '0;
        end else begin
            if (|m_if.tvalid)
                check("onehot_tvalid", 64'($countones(m_if.tvalid)), 1);
            for (int k = 0; k < NP; k++) begin
                if (prev_stall[k]) begin
                    check("hold_valid", m_if.tvalid[k], 1);
                    check("hold_data", m_if.tdata[k*TDW +: TDW], prev_data[k]);
                end
                if (m_if.tvalid[k] && m_if.tready[k]) begin
                    check("beat_expected", q[k].size() > 0, 1);
                    if (q[k].size() > 0) begin
                        logic [65:0] e;
                        e = q[k].pop_front();
                        check($sformatf("beat_p%0d", k),
                              {m_if.tuser[k], m_if.tlast[k], m_if.tdata[k*TDW +: TDW]}, e[33:0]);
                        if (chk_lat)
                            check("latency", 64'(cyc - int'(e[65:34])), 1);
                    end
                    npipe[k]++;
                end
                prev_stall[k] = m_if.tvalid[k] && !m_if.tready[k];
                prev_data[k]  = m_if.tdata[k*TDW +: TDW];
            end
            if (s_if.tvalid[0] && s_if.tready[0]) begin
                if (s_if.tuser[0]) begin
                    if (m_pflag) begin
                        m_asel = m_psel; m_aen = m_pen; m_pflag = 1'b0;
                    end
                    m_mode = (m_aen && m_asel < NP) ? 1 : 2;
                end
                if (m_mode == 1) begin
                    q[m_asel].push_back({32'(cyc), s_if.tuser[0], s_if.tlast[0], s_if.tdata});
                    if (s_if.tuser[0]) m_frames++;
                end else begin
                    m_drops++;
                end
            end
            if (vsync) begin
                m_psel = int'(app0[1:0]); m_pen = app0[31]; m_pflag = 1'b1;
            end
        end
    end

    initial begin
        m_if.tready = '1;
        forever begin
            @(posedge clk); #1;
            m_if.tready = (rdy_fixed & ~rdy_rand) | (NP'($urandom) & rdy_rand);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync(input logic [31:0] v);
        vsync = 1'b1; app0 = v;
        step(1);
        vsync = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic user, input logic last,
                             input logic vs, input logic [31:0] vsval);
        logic got;
        s_if.tdata = d; s_if.tuser = user; s_if.tlast = last; s_if.tvalid = 1'b1;
        vsync = vs;
        if (vs) app0 = vsval;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = s_if.tready[0];
            step(1);
            vsync = 1'b0;
        end
        check("accept_timeout", got, 1);
    endtask

    task automatic send_frame(input int lines, input int bpl, input int vs_at,
                              input logic [31:0] vsval, input logic gaps);
        int idx = 0;
        for (int l = 0; l < lines; l++)
            for (int b = 0; b < bpl; b++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    s_if.tvalid = 1'b0;
                    step(1);
                end
                send_beat($urandom, idx == 0, b == bpl - 1, idx == vs_at, vsval);
                idx++;
            end
        s_if.tvalid = 1'b0;
    endtask

    initial begin
        int nb, p0, p3;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = '0;
        step(3);
        check("rst_tready", s_if.tready, 0);
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_active_sel", active_sel, DSEL);
        check("rst_active_en", active_en, 1);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        #1;
        check("tready_after_rst", s_if.tready, 1);

        for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0, 1'b0, 1'b0, '0);
        s_if.tvalid = 1'b0;
        step(3);
        check("pre_sof_drops", drop_cnt, 3);
        check("pre_sof_outputs", 64'(npipe[0] + npipe[1] + npipe[2] + npipe[3]), 0);

        pulse_vsync(32'h8000_0002);
        chk_lat = 1'b1;
        send_frame(2, 4, -1, '0, 1'b0);
        step(4);
        chk_lat = 1'b0;
        check("s1_pipe2", 64'(npipe[2]), 8);
        check("s1_other", 64'(npipe[0] + npipe[1] + npipe[3]), 0);
        check("s1_frame_cnt", frame_cnt, 1);

        send_frame(2, 4, 3, 32'h8000_0001, 1'b0);
        send_frame(2, 4, -1, '0, 1'b0);
        step(4);
        check("s2_pipe2", 64'(npipe[2]), 16);
        check("s2_pipe1", 64'(npipe[1]), 8);
        check("s2_active_sel", active_sel, 1);

        send_frame(1, 4, 0, 32'h8000_0000, 1'b0);
        send_frame(1, 4, -1, '0, 1'b0);
        step(4);
        check("sof_vsync_pipe1", 64'(npipe[1]), 12);
        check("sof_vsync_pipe0", 64'(npipe[0]), 4);

        pulse_vsync(32'h8000_0002);
        pulse_vsync(32'h8000_0003);
        send_frame(1, 4, -1, '0, 1'b0);
        step(4);
        check("double_vsync_pipe3", 64'(npipe[3]), 4);
        check("double_vsync_pipe2", 64'(npipe[2]), 16);
        check("frames_directed", frame_cnt, 6);

        pulse_vsync(32'h0000_0003);
        send_frame(2, 4, -1, '0, 1'b0);
        step(4);
        check("disabled_drops", drop_cnt, 11);
        check("disabled_outputs", 64'(npipe[0] + npipe[1] + npipe[2] + npipe[3]), 36);
        check("disabled_active_en", active_en, 0);

        pulse_vsync(32'h8000_0001);
        rdy_rand = 4'b0010;
        nb = 0;
        for (int f = 0; f < 3; f++) begin
            int l = $urandom_range(1, 3);
            int b = $urandom_range(1, 6);
            send_frame(l, b, -1, '0, 1'b1);
            nb += l * b;
        end
        step(30);
        check("stall_pipe1_count", 64'(npipe[1]), 64'(12 + nb));
        check("stall_frame_cnt", frame_cnt, 9);

        rdy_rand = '1;
        for (int f = 0; f < 20; f++) begin
            logic [31:0] v;
            v = {1'($urandom_range(0, 3) != 0), 29'd0, 2'($urandom)};
            if ($urandom_range(0, 1) == 1) pulse_vsync(v);
            send_frame($urandom_range(1, 3), $urandom_range(1, 5),
                       $urandom_range(0, 1) == 1 ? $urandom_range(0, 4) : -1, v, 1'b1);
            step($urandom_range(0, 3));
        end
        step(30);
        check("rand_frame_cnt", frame_cnt, 16'(m_frames));
        check("rand_drop_cnt", drop_cnt, 16'(m_drops));

        rdy_rand = '0;
        rdy_fixed = 4'b1110;
        pulse_vsync(32'h8000_0000);
        send_beat(32'hA5A5_0001, 1'b1, 1'b0, 1'b0, '0);
        s_if.tvalid = 1'b0;
        check("stalled_pipe0_valid", m_if.tvalid[0], 1);
        rst = 1'b1;
        step(1);
        check("rst_midframe_tvalid", m_if.tvalid, 0);
        check("rst_midframe_tready", s_if.tready, 0);
        rst = 1'b0;
        rdy_fixed = '1;
        p0 = npipe[0]; p3 = npipe[3];
        send_frame(1, 4, -1, '0, 1'b0);
        step(6);
        check("resume_default_pipe", 64'(npipe[3] - p3), 4);
        check("resume_pipe0_none", 64'(npipe[0] - p0), 0);
        check("resume_active_sel", active_sel, DSEL);
        check("resume_frame_cnt", frame_cnt, 1);

        for (int k = 0; k < NP; k++)
            check($sformatf("leftover_p%0d", k), 64'(q[k].size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
